// File: rtl/ad_cmos_rx_framer.sv
// ad_cmos_rx_framer: DDR CMOS RX capture, frame-alignment lock FSM and per-clock I/Q sample output.
// Define AD_CMOS_RX_ERRCNT_EN to build the saturating frame error counter behind err_count.
module ad_cmos_rx_framer #(
  parameter int DATA_WIDTH   = 12,
  parameter int LOCK_PERIODS = 4,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_frame_in,
  input  logic                  mode_2ch,
  output logic                  out_valid,
  output logic                  out_ch,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  locked,
  output logic                  frame_err,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam int         CapW     = DATA_WIDTH + 1;
  localparam logic [3:0] LockGoal = 4'(LOCK_PERIODS);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  // Behavioural IDDR bank (SAME_EDGE_PIPELINED, no reset, INIT 0); frame line is the MSB.
  logic [CapW-1:0] riseCap_q, fallCap_q, q1_q, q2_q;

  always_ff @(posedge clk) begin
    riseCap_q <= {rx_frame_in, rx_data_in};
    q1_q      <= riseCap_q;
    q2_q      <= fallCap_q;
  end

  always_ff @(negedge clk) begin
    fallCap_q <= {rx_frame_in, rx_data_in};
  end

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [3:0]            good_q, good_d;
  logic                  mode_q, mode_d;
  logic                  prevFrame_q, prevFrame_d;
  logic                  outValid_q, outValid_d;
  logic                  outCh_q, outCh_d;
  logic [DATA_WIDTH-1:0] outI_q, outI_d;
  logic [DATA_WIDTH-1:0] outQ_q, outQ_d;
  logic                  locked_q, locked_d;
  logic                  frameErr_q, frameErr_d;

  logic       frameR, frameF, legal, expFrame, violation, chan;
  logic [1:0] lastPhase, phaseNext;

  assign frameR    = q1_q[CapW-1];
  assign frameF    = q2_q[CapW-1];
  assign legal     = (frameR == frameF);
  assign lastPhase = mode_q ? 2'd3 : 2'd1;
  assign phaseNext = (phase_q == lastPhase) ? 2'd0 : phase_q + 2'd1;
  // Frame is high for phases below nch: phase<2 in two-channel mode, phase==0 in one-channel mode.
  assign expFrame  = mode_q ? ~phaseNext[1] : ~phaseNext[0];
  assign violation = ~legal | (frameR != expFrame) | (mode_2ch != mode_q);
  assign chan      = mode_q & phaseNext[0];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    good_d      = good_q;
    mode_d      = mode_q;
    prevFrame_d = frameR;
    outValid_d  = 1'b0;
    locked_d    = 1'b0;
    frameErr_d  = 1'b0;
    outCh_d     = outCh_q;
    outI_d      = outI_q;
    outQ_d      = outQ_q;
    unique case (state_q)
      SEARCH: begin
        if (legal && frameR && !prevFrame_q) begin
          state_d = TRACK;
          phase_d = 2'd0;
          good_d  = 4'd0;
          mode_d  = mode_2ch;
        end
      end
      TRACK: begin
        phase_d = phaseNext;
        if (phaseNext == 2'd0) good_d = good_q + 4'd1;
        if (violation)               state_d = SEARCH;
        else if (good_q == LockGoal) state_d = LOCKED;
      end
      LOCKED: begin
        phase_d = phaseNext;
        if (violation) begin
          state_d    = SEARCH;
          frameErr_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    // Output registers track the state being entered, so lock loss and gain show at the same edge.
    if (state_d == LOCKED) begin
      locked_d   = 1'b1;
      outValid_d = 1'b1;
      outCh_d    = chan;
      outI_d     = q1_q[DATA_WIDTH-1:0];
      outQ_d     = q2_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= SEARCH;
      phase_q     <= 2'd0;
      good_q      <= 4'd0;
      mode_q      <= 1'b0;
      prevFrame_q <= 1'b0;
      outValid_q  <= 1'b0;
      outCh_q     <= 1'b0;
      outI_q      <= '0;
      outQ_q      <= '0;
      locked_q    <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      good_q      <= good_d;
      mode_q      <= mode_d;
      prevFrame_q <= prevFrame_d;
      outValid_q  <= outValid_d;
      outCh_q     <= outCh_d;
      outI_q      <= outI_d;
      outQ_q      <= outQ_d;
      locked_q    <= locked_d;
      frameErr_q  <= frameErr_d;
    end
  end

`ifdef AD_CMOS_RX_ERRCNT_EN
  logic [ERR_WIDTH-1:0] errCount_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      errCount_q <= '0;
    end else if (frameErr_d && (errCount_q != {ERR_WIDTH{1'b1}})) begin
      errCount_q <= errCount_q + ERR_WIDTH'(1);
    end
  end

  assign err_count = errCount_q;
`else
  assign err_count = '0;
`endif

  assign out_valid = outValid_q;
  assign out_ch    = outCh_q;
  assign out_i     = outI_q;
  assign out_q     = outQ_q;
  assign locked    = locked_q;
  assign frame_err = frameErr_q;

endmodule
